// File: rtl/freq_selector.sv
// freq_selector: button front end for the sine PWM generator.
// Synchronises and debounces up/down/run buttons, steps the 12-bit period word N
// with saturation and hold-to-auto-repeat, and toggles the run flag.
module freq_selector #(
    parameter int unsigned DEB_CYCLES    = 50000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned N_MIN         = 1,
    parameter int unsigned N_MAX         = 4095,
    parameter int unsigned N_STEP        = 1,
    parameter int unsigned N_INIT        = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_run,
    output logic [11:0] n_out,
    output logic        opr,
    output logic        n_changed
);

    localparam int unsigned NW       = 12;
    localparam int unsigned AW       = NW + 1;
    localparam int unsigned NB       = 3;
    localparam int unsigned BTN_UP   = 0;
    localparam int unsigned BTN_DOWN = 1;
    localparam int unsigned BTN_RUN  = 2;
    localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMR_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_HOLD,
        ST_REPEAT
    } rep_state_t;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] deb_rise;
    logic [1:0]    step_req;
    logic [AW-1:0] n_wide;
    logic [AW-1:0] up_sum;
    logic [NW-1:0] n_next;

    assign btn_raw  = {btn_run, btn_down, btn_up};
    assign deb_rise = deb & ~deb_q;

    // Two-flop synchroniser on every raw button, plus debounced-level history for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb_q <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             lvl;

        // Debounce: the level follows the synchronised input only after DEB_CYCLES stable clocks
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                lvl <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end

        assign deb[i] = lvl;
    end

    for (genvar r = 0; r < 2; r++) begin : g_rep
        rep_state_t       state;
        logic [TMR_W-1:0] timer;
        logic             step;

        // Repeat FSM: one step on press, another after the hold time, then one per repeat period
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_IDLE;
                timer <= '0;
                step  <= 1'b0;
            end else begin
                step <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (deb_rise[r]) begin
                            step  <= 1'b1;
                            state <= ST_WAIT_HOLD;
                            timer <= '0;
                        end
                    end
                    ST_WAIT_HOLD: begin
                        if (!deb[r]) begin
                            state <= ST_IDLE;
                        end else if (timer == TMR_W'(HOLD_CYCLES - 1)) begin
                            step  <= 1'b1;
                            state <= ST_REPEAT;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!deb[r]) begin
                            state <= ST_IDLE;
                        end else if (timer == TMR_W'(REPEAT_CYCLES - 1)) begin
                            step  <= 1'b1;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign step_req[r] = step;
    end

    // Saturating step arithmetic in 13 bits; simultaneous up and down requests cancel
    always_comb begin
        n_wide = {1'b0, n_out};
        up_sum = n_wide + AW'(N_STEP);
        n_next = n_out;
        if (step_req[BTN_UP] && !step_req[BTN_DOWN]) begin
            n_next = (up_sum > AW'(N_MAX)) ? NW'(N_MAX) : up_sum[NW-1:0];
        end else if (step_req[BTN_DOWN] && !step_req[BTN_UP]) begin
            n_next = (n_wide < (AW'(N_MIN) + AW'(N_STEP))) ? NW'(N_MIN) : NW'(n_wide - AW'(N_STEP));
        end
    end

    // Output registers: N word, change pulse, and run flag toggled on each run press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_out     <= NW'(N_INIT);
            n_changed <= 1'b0;
            opr       <= 1'b0;
        end else begin
            n_out     <= n_next;
            n_changed <= (n_next != n_out);
            if (deb_rise[BTN_RUN]) begin
                opr <= ~opr;
            end
        end
    end

endmodule

// File: tb/tb_freq_selector.sv
// tb_freq_selector: directed bench with a scoreboard of expected N updates
// (value and arrival cycle) checked by a monitor on every n_changed pulse.
module tb_freq_selector;

    localparam int unsigned DEB    = 4;
    localparam int unsigned HOLD   = 20;
    localparam int unsigned REP    = 8;
    localparam int unsigned NMIN   = 1;
    localparam int unsigned NMAX   = 10;
    localparam int unsigned STEP   = 2;
    localparam int unsigned NINIT  = 5;
    localparam int          LAT    = 8;
    localparam int          SETTLE = 14;

    typedef struct {
        int val;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up;
    logic        btn_down;
    logic        btn_run;
    logic [11:0] n_out;
    logic        opr;
    logic        n_changed;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   prev_n = NINIT;
    exp_t sb[$];

    freq_selector #(
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .N_MIN        (NMIN),
        .N_MAX        (NMAX),
        .N_STEP       (STEP),
        .N_INIT       (NINIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_run  (btn_run),
        .n_out    (n_out),
        .opr      (opr),
        .n_changed(n_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_at(input int val, input int at);
        exp_t e;
        e.val = val;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Press the selected buttons for 'hold' clocks, release, and let the debouncers settle
    task automatic tap(input logic u, input logic d, input logic rn, input int hold,
                       input int exp_val, input bit pulse);
        @(posedge clk);
        #1;
        if (pulse) expect_at(exp_val, cyc + LAT);
        btn_up   = u;
        btn_down = d;
        btn_run  = rn;
        repeat (hold) @(posedge clk);
        #1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_run  = 1'b0;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every n_changed pulse must match the next scoreboard entry in value and cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_n = NINIT;
        end else begin
            if (n_changed) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual n_out=%0d cycle=%0d required no pulse", n_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_value", int'(n_out), e.val);
                    chk("pulse_cycle", cyc, e.at);
                    chk("pulse_differs", int'(n_out != 12'(prev_n)), 1);
                end
            end
            prev_n = int'(n_out);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int up_vals[4];
        int up_pul[4];
        int dn_vals[6];
        int dn_pul[6];
        int c;
        int r;

        up_vals = '{7, 9, 10, 10};
        up_pul  = '{1, 1, 1, 0};
        dn_vals = '{8, 6, 4, 2, 1, 1};
        dn_pul  = '{1, 1, 1, 1, 1, 0};

        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_run  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_n", int'(n_out), 5);
        chk("reset_opr", int'(opr), 0);
        chk("reset_chg", int'(n_changed), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single up tap with fixed latency
        tap(1'b1, 1'b0, 1'b0, 10, 7, 1'b1);
        chk("tap_up_n", int'(n_out), 7);
        chk("tap_up_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_n", int'(n_out), 5);
        chk("async_rst_opr", int'(opr), 0);
        chk("async_rst_chg", int'(n_changed), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Bounce shorter than the debounce window is ignored
        for (int k = 0; k < 5; k++) begin
            btn_down = 1'b1;
            repeat (2) @(posedge clk);
            #1 btn_down = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bounce_n", int'(n_out), 5);

        // Saturation at N_MAX then N_MIN
        for (int k = 0; k < 4; k++) begin
            tap(1'b1, 1'b0, 1'b0, 10, up_vals[k], up_pul[k] != 0);
            chk("sat_up_n", int'(n_out), up_vals[k]);
        end
        for (int k = 0; k < 6; k++) begin
            tap(1'b0, 1'b1, 1'b0, 10, dn_vals[k], dn_pul[k] != 0);
            chk("sat_down_n", int'(n_out), dn_vals[k]);
        end

        // Auto-repeat: step on press, after hold, then every repeat period
        @(posedge clk);
        #1;
        c = cyc;
        expect_at(3, c + LAT);
        expect_at(5, c + LAT + HOLD);
        expect_at(7, c + LAT + HOLD + REP);
        expect_at(9, c + LAT + HOLD + 2 * REP);
        expect_at(10, c + LAT + HOLD + 3 * REP);
        btn_up = 1'b1;
        repeat (60) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("repeat_n", int'(n_out), 10);
        chk("repeat_sb_empty", sb.size(), 0);

        // Simultaneous up and down cancel
        tap(1'b1, 1'b1, 1'b0, 10, 0, 1'b0);
        chk("simul_n", int'(n_out), 10);

        // Run toggle on each press
        chk("run_opr0", int'(opr), 0);
        tap(1'b0, 1'b0, 1'b1, 10, 0, 1'b0);
        chk("run_opr1", int'(opr), 1);
        tap(1'b0, 1'b0, 1'b1, 10, 0, 1'b0);
        chk("run_opr2", int'(opr), 0);
        tap(1'b0, 1'b0, 1'b1, 10, 0, 1'b0);
        chk("run_opr3", int'(opr), 1);
        chk("run_n_kept", int'(n_out), 10);

        // Reset during WAIT_HOLD with the button still held
        @(posedge clk);
        #1;
        c = cyc;
        expect_at(8, c + LAT);
        btn_down = 1'b1;
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midhold_rst_n", int'(n_out), 5);
        chk("midhold_rst_opr", int'(opr), 0);
        chk("midhold_rst_chg", int'(n_changed), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r = cyc;
        expect_at(3, r + LAT);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("midhold_still5", int'(n_out), 5);
        @(negedge clk);
        chk("midhold_now3", int'(n_out), 3);
        #1 btn_down = 1'b0;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        chk("final_n", int'(n_out), 3);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
